// File: rtl/bin16_to_bcd_seq_if.sv
// Handshake and data bundle between a binary producer and the BCD converter.
// The master drives start/bin; the slave returns busy/done and the packed BCD word.
interface bin16_to_bcd_seq_if;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [23:0] bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to 6-digit packed BCD converter (double dabble, one bit per clock).
// Optional leading-zero blanking replaces upper zero digits with 4'hF for seg_display.
module bin16_to_bcd_seq #(
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic               clk,
  input  logic               rst_,
  bin16_to_bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state, state_nxt;
  logic [15:0] shreg;
  logic [19:0] work;
  logic [19:0] work_adj;
  logic [3:0]  cnt;
  logic [23:0] bcd_r;
  logic [23:0] bcd_load;
  logic        done_r;
  logic        leading;

  always_ff @(posedge clk) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd15) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-nibble add-3 with no carry between digits; a corrected digit tops out at 4'hC.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 5; i++) begin
      if (work[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

  // Blank zero digits from the top down until the first nonzero digit; digit 0 always shows.
  always_comb begin
    bcd_load = {4'h0, work};
    leading  = 1'b1;
    if (LZ_BLANK) begin
      for (int i = 5; i >= 1; i--) begin
        if (bcd_load[4*i +: 4] != 4'h0) leading = 1'b0;
        else if (leading)               bcd_load[4*i +: 4] = 4'hF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      shreg  <= 16'h0000;
      work   <= 20'h00000;
      cnt    <= 4'd0;
      bcd_r  <= 24'h000000;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg <= bus.bin;
            work  <= 20'h00000;
            cnt   <= 4'd0;
          end
        end
        SHIFT: begin
          {work, shreg} <= {work_adj[18:0], shreg, 1'b0};
          cnt           <= cnt + 4'd1;
        end
        LOAD: begin
          bcd_r  <= bcd_load;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.bcd  = bcd_r;

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Self-checking bench for bin16_to_bcd_seq: two instances (no blanking / blanking) share stimulus,
// a scoreboard queue holds expectations pushed on acceptance and popped on done.
module tb_bin16_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_;
  logic        start;
  logic [15:0] bin;

  always #5 clk = ~clk;

  bin16_to_bcd_seq_if bus0 ();
  bin16_to_bcd_seq_if bus1 ();

  assign bus0.start = start;
  assign bus0.bin   = bin;
  assign bus1.start = start;
  assign bus1.bin   = bin;

  bin16_to_bcd_seq #(.LZ_BLANK(1'b0)) dut0 (.clk(clk), .rst_(rst_), .bus(bus0));
  bin16_to_bcd_seq #(.LZ_BLANK(1'b1)) dut1 (.clk(clk), .rst_(rst_), .bus(bus1));

  typedef struct {
    logic [15:0] val;
    logic [23:0] e0;
    logic [23:0] e1;
  } vec_t;

  typedef struct {
    logic [23:0] e0;
    logic [23:0] e1;
    int unsigned accCyc;
  } exp_t;

  exp_t        sbq[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          passed = 0;
  int          doneCount = 0;
  int unsigned cyc = 0;
  bit          rstEdge = 1'b1;
  bit          armed = 1'b0;
  logic [23:0] nextE0 = 24'h0;
  logic [23:0] nextE1 = 24'h0;
  logic [23:0] prev0, prev1;

  // Reference: decimal digits by division, blanking by counting significant digits.
  function automatic logic [23:0] refBcd(input int v, input bit lz);
    logic [23:0] r;
    int t;
    int nd;
    r = 24'h0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    if (lz) begin
      nd = 1;
      for (int p = 10; p <= v; p = p * 10) nd++;
      for (int i = nd; i < 6; i++) r[4*i +: 4] = 4'hF;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    cyc++;
    rstEdge = !rst_;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (armed && !rstEdge) begin
      if (bus0.done) begin
        doneCount++;
        checkOutput("done_expected", (sbq.size() != 0), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          checkOutput("bcd_nolz", bus0.bcd, e.e0);
          checkOutput("bcd_lz", bus1.bcd, e.e1);
          checkOutput("latency", cyc - e.accCyc, 17);
          checkOutput("busy_at_done", bus0.busy, 0);
          checkOutput("done_lz_sync", bus1.done, 1);
        end
      end else begin
        checkOutput("bcd_stable_nolz", bus0.bcd, prev0);
        checkOutput("bcd_stable_lz", bus1.bcd, prev1);
      end
    end
    if (rstEdge) sbq.delete();
    else if (rst_ && start && !bus0.busy) sbq.push_back('{nextE0, nextE1, cyc + 1});
    prev0 = bus0.bcd;
    prev1 = bus1.bcd;
  end

  task automatic waitAccept();
    int n = 0;
    @(negedge clk);
    while (bus0.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus0.busy) checkOutput("accept_timeout", bus0.busy, 0);
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [23:0] e0, input logic [23:0] e1);
    @(posedge clk);
    #1;
    bin    = v;
    nextE0 = e0;
    nextE1 = e1;
    start  = 1'b1;
    waitAccept();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checkOutput("done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int unsigned lastAcc;
    int unsigned thisAcc;

    vecs[0] = '{16'd0,     24'h000000, 24'hFFFFF0};
    vecs[1] = '{16'd65535, 24'h065535, 24'hF65535};
    vecs[2] = '{16'd65025, 24'h065025, 24'hF65025};
    vecs[3] = '{16'd9,     24'h000009, 24'hFFFFF9};
    vecs[4] = '{16'd1000,  24'h001000, 24'hFF1000};
    vecs[5] = '{16'd1234,  24'h001234, 24'hFF1234};
    vecs[6] = '{16'd10,    24'h000010, 24'hFFFF10};
    vecs[7] = '{16'd50000, 24'h050000, 24'hF50000};
    vecs[8] = '{16'd10009, 24'h010009, 24'hF10009};

    start = 1'b0;
    bin   = 16'h0;
    rst_  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;
    @(negedge clk);
    checkOutput("reset_bcd_nolz", bus0.bcd, 24'h000000);
    checkOutput("reset_bcd_lz", bus1.bcd, 24'h000000);
    checkOutput("reset_busy", bus0.busy, 0);
    checkOutput("reset_done", bus0.done, 0);
    armed = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].val, vecs[i].e0, vecs[i].e1);
      @(negedge clk);
      checkOutput("busy_after_accept", bus0.busy, 1);
      waitIdle();
    end

    // A second start mid-conversion must be dropped.
    d0 = doneCount;
    applyStimulus(16'd1234, 24'h001234, 24'hFF1234);
    repeat (4) @(posedge clk);
    #1;
    bin   = 16'd4321;
    start = 1'b1;
    @(negedge clk);
    checkOutput("busy_during_ignored", bus0.busy, 1);
    @(posedge clk);
    #1 start = 1'b0;
    waitIdle();
    repeat (25) @(negedge clk);
    checkOutput("ignored_done_count", doneCount - d0, 1);
    checkOutput("ignored_bcd", bus0.bcd, 24'h001234);

    // Reset in the middle of a conversion aborts it silently.
    d0 = doneCount;
    applyStimulus(16'd500, 24'h000500, 24'hFFF500);
    repeat (7) @(posedge clk);
    #1 rst_ = 1'b0;
    @(posedge clk);
    #1 rst_ = 1'b1;
    @(negedge clk);
    checkOutput("abort_bcd_nolz", bus0.bcd, 24'h000000);
    checkOutput("abort_bcd_lz", bus1.bcd, 24'h000000);
    checkOutput("abort_busy", bus0.busy, 0);
    checkOutput("abort_done", bus0.done, 0);
    repeat (25) @(negedge clk);
    checkOutput("abort_done_count", doneCount - d0, 0);
    applyStimulus(16'd500, 24'h000500, 24'hFFF500);
    waitIdle();

    // Start held high: back-to-back conversions every 18 clocks.
    lastAcc = 0;
    @(posedge clk);
    #1 start = 1'b1;
    for (int v = 0; v <= 300; v++) begin
      bin    = 16'(v);
      nextE0 = refBcd(v, 1'b0);
      nextE1 = refBcd(v, 1'b1);
      waitAccept();
      thisAcc = cyc + 1;
      if (v > 0) checkOutput("b2b_period", thisAcc - lastAcc, 18);
      lastAcc = thisAcc;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    waitIdle();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
